// File: rtl/cache_set_ctrl.sv
// Sequencing controller in front of one K-way cache set and a backing memory.
// Round-robin shares the set between N_REQ requesters, one transaction at a time.
module cache_set_ctrl #(
  parameter int ADDR_WIDTH   = 8,
  parameter int LINE_WIDTH   = 32,
  parameter int N_REQ        = 2,
  parameter int FILL_TIMEOUT = 16
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ-1:0]            req_write,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*LINE_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [LINE_WIDTH-1:0]       rsp_data,
  output logic                        err,
  output logic                        set_enable,
  output logic                        set_read,
  output logic                        set_write,
  output logic [ADDR_WIDTH-1:0]       set_in_addr,
  output logic [LINE_WIDTH-1:0]       set_in_val,
  input  logic                        set_hit,
  input  logic [LINE_WIDTH-1:0]       set_out_val,
  output logic                        mem_req,
  output logic                        mem_write,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [LINE_WIDTH-1:0]       mem_wdata,
  input  logic                        mem_ack,
  input  logic [LINE_WIDTH-1:0]       mem_rdata
);

  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(FILL_TIMEOUT + 1);
  localparam logic [N_REQ-1:0] ID_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_CHECK  = 3'd2,
    S_RMEM   = 3'd3,
    S_WMEM   = 3'd4,
    S_FILL   = 3'd5,
    S_RESP   = 3'd6
  } state_e;

  state_e                state_q, state_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d, id_q, id_d, grant_id;
  logic                  grant_found;
  logic                  write_q, write_d, err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [N_REQ-1:0]      rsp_valid_q;
  logic [LINE_WIDTH-1:0] rsp_data_q, set_in_val_q, mem_wdata_q;
  logic                  set_enable_q, set_read_q, set_write_q, mem_req_q, mem_write_q;
  logic [ADDR_WIDTH-1:0] set_in_addr_q, mem_addr_q;

  // First valid requester found scanning upward from rr_ptr_q, wrapping.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end else begin
        grant_found = grant_found;
      end
    end
  end

  assign req_ready = (reset_n && (state_q == S_IDLE) && grant_found) ? (ID_ONE << grant_id)
                                                                     : '0;

  // Transaction sequencing and capture of the accepted request.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          id_d     = grant_id;
          write_d  = req_write[grant_id];
          addr_d   = req_addr[int'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d  = req_wdata[int'(grant_id)*LINE_WIDTH +: LINE_WIDTH];
          rr_ptr_d = (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + ID_W'(1);
          state_d  = req_write[grant_id] ? S_WMEM : S_LOOKUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOOKUP: state_d = S_CHECK;
      S_CHECK: begin
        if (set_hit) begin
          rdata_d = set_out_val;
          state_d = S_RESP;
        end else begin
          state_d = S_RMEM;
        end
      end
      S_RMEM: begin
        if (mem_ack) begin
          wdata_d = mem_rdata;
          rdata_d = mem_rdata;
          cnt_d   = '0;
          state_d = S_FILL;
        end else begin
          state_d = S_RMEM;
        end
      end
      S_WMEM: begin
        if (mem_ack) begin
          cnt_d   = '0;
          state_d = S_FILL;
        end else begin
          state_d = S_WMEM;
        end
      end
      S_FILL: begin
        // The hit seen in the first fill cycle still reflects the previous operation.
        if ((cnt_q != '0) && set_hit) begin
          state_d = S_RESP;
        end else if (cnt_q == CNT_W'(FILL_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, capture and output registers; outputs are decoded from the next state.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      id_q          <= '0;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      cnt_q         <= '0;
      err_q         <= 1'b0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      set_enable_q  <= 1'b0;
      set_read_q    <= 1'b0;
      set_write_q   <= 1'b0;
      set_in_addr_q <= '0;
      set_in_val_q  <= '0;
      mem_req_q     <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      id_q          <= id_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      rsp_valid_q   <= (state_d == S_RESP) ? (ID_ONE << id_d) : '0;
      rsp_data_q    <= ((state_d == S_RESP) && !write_d) ? rdata_d : '0;
      set_enable_q  <= (state_d == S_LOOKUP) || (state_d == S_FILL);
      set_read_q    <= (state_d == S_LOOKUP);
      set_write_q   <= (state_d == S_FILL);
      set_in_addr_q <= ((state_d == S_LOOKUP) || (state_d == S_FILL)) ? addr_d : '0;
      set_in_val_q  <= (state_d == S_FILL) ? wdata_d : '0;
      mem_req_q     <= (state_d == S_RMEM) || (state_d == S_WMEM);
      mem_write_q   <= (state_d == S_WMEM);
      mem_addr_q    <= ((state_d == S_RMEM) || (state_d == S_WMEM)) ? addr_d : '0;
      mem_wdata_q   <= (state_d == S_WMEM) ? wdata_d : '0;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign err         = err_q;
  assign set_enable  = set_enable_q;
  assign set_read    = set_read_q;
  assign set_write   = set_write_q;
  assign set_in_addr = set_in_addr_q;
  assign set_in_val  = set_in_val_q;
  assign mem_req     = mem_req_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_cache_set_ctrl.sv
// Scoreboard bench for cache_set_ctrl: behavioural set and memory models,
// a flat reference memory for expected read data and a round-robin grant model.
module tb_cache_set_ctrl;
  localparam int AW = 8, LW = 32, N = 2, FT = 16;

  logic clock = 1'b0, reset_n = 1'b0;
  logic [N-1:0]    req_valid = '0, req_write = '0;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*LW-1:0] req_wdata = '0;
  logic [LW-1:0]   rsp_data;
  logic            err, set_enable, set_read, set_write, mem_req, mem_write;
  logic [AW-1:0]   set_in_addr, mem_addr;
  logic [LW-1:0]   set_in_val, mem_wdata;
  logic            set_hit = 1'b0, mem_ack = 1'b0;
  logic [LW-1:0]   set_out_val = '0, mem_rdata = '0;

  cache_set_ctrl #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .N_REQ(N), .FILL_TIMEOUT(FT)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err(err),
    .set_enable(set_enable), .set_read(set_read), .set_write(set_write),
    .set_in_addr(set_in_addr), .set_in_val(set_in_val),
    .set_hit(set_hit), .set_out_val(set_out_val),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  typedef struct { int id; logic [31:0] data; } exp_t;
  exp_t exp_q[$];
  int   grant_log[$];

  int n_checks = 0, n_fail = 0;
  int cyc = 0, acc_cyc = 0, rsp_cyc = 0, acc_count = 0, rsp_count = 0, rr_model = 0;
  int mem_fixed = -1, mem_req_cycles = 0, fill_cycles = 0;
  bit no_hit_mode = 1'b0, last_mem_write = 1'b0;
  logic [31:0] last_mem_wdata = '0;
  logic [N-1:0] acc_mask = '0;
  logic [31:0] mem_ref [0:255];
  logic [31:0] bmem    [0:255];
  logic [31:0] sdata   [0:255];
  bit          svalid  [0:255];
  logic [7:0]  sorder[$];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void set_store(logic [7:0] a, logic [31:0] v);
    logic [7:0] ev;
    if (!svalid[a]) begin
      if (sorder.size() == 4) begin
        ev = sorder.pop_front();
        svalid[ev] = 1'b0;
      end
      sorder.push_back(a);
      svalid[a] = 1'b1;
    end
    sdata[a] = v;
  endfunction

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Cache set model: registered hit/data, multi-cycle write, hit held while idle.
  initial begin : set_model
    bit en, rd, wr, done;
    logic [7:0] a;
    logic [31:0] v;
    int wc, wl;
    done = 1'b0; wc = 0; wl = 1;
    forever begin
      @(negedge clock);
      en = set_enable; rd = set_read; wr = set_write; a = set_in_addr; v = set_in_val;
      if (wr) fill_cycles++;
      @(posedge clock); #1;
      if (en && rd) begin
        set_hit     = svalid[a];
        set_out_val = svalid[a] ? sdata[a] : $urandom();
        done = 1'b0; wc = 0;
      end else if (en && wr) begin
        if (!done) begin
          set_hit = 1'b0;
          wc++;
          if (!no_hit_mode && wc >= wl) begin
            set_store(a, v);
            set_hit = 1'b1;
            done    = 1'b1;
          end
        end
      end else begin
        done = 1'b0; wc = 0; wl = $urandom_range(1, 3);
      end
    end
  end

  // Backing memory model with fixed or random ack delay.
  initial begin : mem_model
    int cnt, lim;
    cnt = 0; lim = 0;
    forever begin
      @(posedge clock); #1;
      mem_ack = 1'b0;
      if (mem_req) begin
        mem_req_cycles++;
        if (cnt >= lim) begin
          mem_ack = 1'b1;
          if (mem_write) begin
            bmem[mem_addr] = mem_wdata;
            last_mem_write = 1'b1;
            last_mem_wdata = mem_wdata;
            mem_rdata      = $urandom();
          end else begin
            mem_rdata      = bmem[mem_addr];
            last_mem_write = 1'b0;
          end
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
        lim = (mem_fixed >= 0) ? mem_fixed : int'($urandom_range(0, 4));
      end
    end
  end

  // Monitor: grant checking against the round-robin model, expectation push, response pop.
  initial begin : monitor
    exp_t e;
    int eid, idx;
    logic [7:0] a;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        exp_q.delete();
        rr_model  = 0;
        acc_mask  = '0;
        acc_count = rsp_count;
      end else begin
        if (rsp_valid != '0) begin
          rsp_cyc = cyc;
          rsp_count++;
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", 64'(rsp_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("rsp_id", 64'(rsp_valid), 64'd1 << e.id);
            check("rsp_data", 64'(rsp_data), 64'(e.data));
          end
        end
        if (req_ready != '0) begin
          eid = -1;
          for (int k = 0; k < N; k++) begin
            idx = (rr_model + k) % N;
            if (eid < 0 && req_valid[idx]) eid = idx;
          end
          check("grant", 64'(req_ready), (eid < 0) ? 64'd0 : (64'd1 << eid));
          if (eid >= 0) begin
            a = req_addr[eid*AW +: AW];
            if (req_write[eid]) begin
              mem_ref[a] = req_wdata[eid*LW +: LW];
              e.data = 32'd0;
            end else begin
              e.data = mem_ref[a];
            end
            e.id = eid;
            exp_q.push_back(e);
            grant_log.push_back(eid);
            rr_model = (eid + 1) % N;
            acc_mask[eid] = 1'b1;
            acc_count++;
            acc_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    while (rsp_count != acc_count && t < 400) begin
      @(negedge clock);
      t++;
    end
    check("rsp_timeout", 64'(rsp_count == acc_count), 64'd1);
  endtask

  task automatic do_req(int i, bit wr, logic [7:0] a, logic [31:0] d, bit wait_rsp);
    int t;
    @(posedge clock); #1;
    req_valid[i] = 1'b1; req_write[i] = wr;
    req_addr[i*AW +: AW] = a; req_wdata[i*LW +: LW] = d;
    t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (!req_ready[i] && t < 200);
    check("accept", 64'(req_ready[i]), 64'd1);
    @(posedge clock); #1;
    req_valid[i] = 1'b0;
    if (wait_rsp) wait_idle();
  endtask

  task automatic raise(int i);
    logic [7:0] a;
    a = 8'($urandom_range(0, 7)) | (($urandom_range(0, 1) == 1) ? 8'h10 : 8'h00);
    req_valid[i] = 1'b1;
    req_write[i] = ($urandom_range(0, 3) == 0);
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*LW +: LW] = $urandom();
  endtask

  task automatic run_traffic(int n, bit always_on);
    int a0, t;
    a0 = acc_count; t = 0;
    acc_mask = '0;
    forever begin
      @(posedge clock); #1;
      t++;
      for (int i = 0; i < N; i++) if (acc_mask[i]) req_valid[i] = 1'b0;
      acc_mask = '0;
      if (acc_count - a0 >= n || t >= 4000) break;
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && (always_on || $urandom_range(0, 2) == 0)) raise(i);
    end
    req_valid = '0;
    check("traffic_done", 64'(acc_count - a0 >= n), 64'd1);
    wait_idle();
  endtask

  task automatic check_zero(string tag);
    check({tag, "_ctrl"}, 64'({req_ready, rsp_valid, err, set_enable, set_read, set_write,
                               mem_req, mem_write}), 64'd0);
    check({tag, "_addr"}, 64'({set_in_addr, mem_addr, rsp_data}), 64'd0);
    check({tag, "_wdata"}, {set_in_val, mem_wdata}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int r0, t;
    for (int a = 0; a < 256; a++) begin
      mem_ref[a] = {8'(a), ~8'(a), 8'(a) ^ 8'h5A, 8'hC3};
      bmem[a]    = mem_ref[a];
      svalid[a]  = 1'b0;
      sdata[a]   = '0;
    end
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_zero("reset");
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Read miss filled from memory with a fixed ack delay.
    bmem[8'h10] = 32'hDEADBEEF; mem_ref[8'h10] = 32'hDEADBEEF;
    mem_fixed = 2; fill_cycles = 0; mem_req_cycles = 0;
    do_req(0, 1'b0, 8'h10, 32'd0, 1'b1);
    check("miss_memreq", 64'(mem_req_cycles > 0), 64'd1);
    check("miss_fill_held", 64'(fill_cycles >= 2), 64'd1);

    // Repeat read hits: no memory traffic, response three cycles after accept.
    mem_req_cycles = 0;
    do_req(1, 1'b0, 8'h10, 32'd0, 1'b1);
    check("hit_latency", 64'(rsp_cyc - acc_cyc), 64'd3);
    check("hit_no_memreq", 64'(mem_req_cycles), 64'd0);

    // Write-through, then the set holds the new value.
    do_req(0, 1'b1, 8'h10, 32'h12345678, 1'b1);
    check("wr_mem_write", 64'(last_mem_write), 64'd1);
    check("wr_mem_wdata", 64'(last_mem_wdata), 64'h12345678);
    mem_req_cycles = 0;
    do_req(1, 1'b0, 8'h10, 32'd0, 1'b1);
    check("wr_then_hit_no_memreq", 64'(mem_req_cycles), 64'd0);

    // Both requesters always valid: grants alternate.
    mem_fixed = -1;
    grant_log.delete();
    run_traffic(6, 1'b1);
    for (int k = 0; k < 6; k++)
      check("alternate", 64'((k < grant_log.size()) ? grant_log[k] : -1), 64'(k % 2));
    check("err_before_timeout", 64'(err), 64'd0);

    // Set never completes the fill: timeout raises err, response still issued.
    no_hit_mode = 1'b1; fill_cycles = 0;
    do_req(0, 1'b0, 8'h80, 32'd0, 1'b1);
    check("timeout_fill_cycles", 64'(fill_cycles), 64'(FT));
    check("timeout_err", 64'(err), 64'd1);
    no_hit_mode = 1'b0;
    do_req(1, 1'b0, 8'h11, 32'd0, 1'b1);
    check("err_sticky", 64'(err), 64'd1);

    // Reset during a memory read drops the transaction and the round-robin pointer.
    mem_fixed = 20;
    do_req(0, 1'b0, 8'h90, 32'd0, 1'b0);
    t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (!mem_req && t < 20);
    check("rmem_reached", 64'(mem_req), 64'd1);
    r0 = rsp_count;
    @(posedge clock); #1;
    reset_n = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    check_zero("midreset");
    @(posedge clock); #1;
    reset_n = 1'b1;
    mem_fixed = -1;
    repeat (3) @(negedge clock);
    check("midreset_no_rsp", 64'(rsp_count), 64'(r0));
    grant_log.delete();
    run_traffic(2, 1'b1);
    check("post_reset_first", 64'((grant_log.size() > 0) ? grant_log[0] : -1), 64'd0);
    do_req(1, 1'b0, 8'h12, 32'd0, 1'b1);

    // Random mixed traffic.
    run_traffic(60, 1'b0);
    run_traffic(20, 1'b1);

    repeat (4) @(negedge clock);
    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
